// File: rtl/cpu_step_ctrl_pkg.sv
// Shared types for the processor run-control sequencer.
// State encodings are fixed because state_o is visible on the board.
package cpu_step_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    RST_HOLD = 3'd0,
    HALTED   = 3'd1,
    STEP     = 3'd2,
    RUN_N    = 3'd3,
    RUN_FREE = 3'd4,
    BREAK    = 3'd5
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: sync clear wins over enable,
// and the count sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en && (cnt != '1))
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/cpu_step_ctrl.sv
// Run-control sequencer: step / run-N / free-run / stop for the core.
// Define CPU_STEP_BP_EN to build in the PC breakpoint and BREAK state.
module cpu_step_ctrl
  import cpu_step_ctrl_pkg::*;
#(
  parameter int PC_W         = 32,
  parameter int CNT_W        = 16,
  parameter int RESET_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step_pulse,
  input  logic             run_pulse,
  input  logic             stop_pulse,
  input  logic             rst_req,
  input  logic [CNT_W-1:0] run_count,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  pc_in,
  output logic             cpu_en,
  output logic             cpu_rst,
  output logic             halted,
  output logic             bp_hit,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] cyc_cnt
);

  localparam int HW = $clog2(RESET_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(RESET_CYCLES - 1);

  state_t           state, nxt;
  logic [HW-1:0]    hold, hold_nx;
  logic [CNT_W-1:0] rem, rem_nx;
  logic             running;
  logic             hit;

  assign running = (state == RUN_N) || (state == RUN_FREE);

`ifdef CPU_STEP_BP_EN
  logic bp_mask;

  assign hit = running && bp_en && (pc_in == bp_addr) && !bp_mask;

  // Masked while parked so a resume executes past the breakpoint PC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      bp_mask <= 1'b1;
    else if ((state == HALTED) || (state == BREAK))
      bp_mask <= 1'b1;
    else if (cpu_en && (state != RST_HOLD))
      bp_mask <= 1'b0;
  end
`else
  logic unused_bp;

  assign unused_bp = ^{bp_en, bp_addr, pc_in};
  assign hit       = 1'b0;
`endif

  always_comb begin
    nxt     = state;
    hold_nx = hold;
    rem_nx  = rem;
    cpu_en  = 1'b0;
    unique case (state)
      RST_HOLD: begin
        cpu_en = 1'b1;
        if (hold == '0)
          nxt = HALTED;
        else
          hold_nx = hold - 1'b1;
      end
      HALTED, BREAK: begin
        if (!stop_pulse && step_pulse) begin
          nxt = STEP;
        end else if (!stop_pulse && run_pulse) begin
          if (run_count == '0) begin
            nxt = RUN_FREE;
          end else begin
            nxt    = RUN_N;
            rem_nx = run_count;
          end
        end
      end
      STEP: begin
        cpu_en = 1'b1;
        nxt    = HALTED;
      end
      RUN_N: begin
        cpu_en = !stop_pulse && !hit;
        if (stop_pulse) begin
          nxt    = HALTED;
          rem_nx = '0;
        end else if (hit) begin
          nxt    = BREAK;
          rem_nx = '0;
        end else begin
          rem_nx = rem - 1'b1;
          if (rem == CNT_W'(1))
            nxt = HALTED;
        end
      end
      RUN_FREE: begin
        cpu_en = !stop_pulse && !hit;
        if (stop_pulse)
          nxt = HALTED;
        else if (hit)
          nxt = BREAK;
      end
      default: begin
        nxt     = RST_HOLD;
        hold_nx = HOLD_INIT;
        rem_nx  = '0;
      end
    endcase
    if (rst_req) begin
      nxt     = RST_HOLD;
      hold_nx = HOLD_INIT;
      rem_nx  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RST_HOLD;
      hold  <= HOLD_INIT;
      rem   <= '0;
    end else begin
      state <= nxt;
      hold  <= hold_nx;
      rem   <= rem_nx;
    end
  end

  assign cpu_rst = (state == RST_HOLD);
  assign halted  = (state == HALTED) || (state == BREAK);
  assign bp_hit  = (state == BREAK);
  assign state_o = state;

  sat_counter #(
    .W(CNT_W)
  ) u_cyc (
    .clk  (clk),
    .rst_n(reset),
    .en   (cpu_en && !cpu_rst),
    .clr  (rst_req),
    .cnt  (cyc_cnt)
  );

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl plus a CNT_W=4 instance
// for saturation and asynchronous reset.
module tb_cpu_step_ctrl;

  logic        clk = 1'b0;
  logic        reset, step_pulse, run_pulse, stop_pulse, rst_req;
  logic [15:0] run_count;
  logic        bp_en;
  logic [31:0] bp_addr, pc;
  logic        cpu_en, cpu_rst, halted, bp_hit;
  logic [2:0]  state_o;
  logic [15:0] cyc_cnt;

  logic        reset4, run4;
  logic        en4, rst4, halted4, hit4;
  logic [2:0]  state4;
  logic [3:0]  cyc4;

  int n_chk  = 0;
  int n_pass = 0;
  int n;

  always #5 clk = ~clk;

  // Core model: PC advances by 4 on every enabled cycle.
  always @(posedge clk)
    if (cpu_rst) pc <= '0;
    else if (cpu_en) pc <= pc + 32'd4;

  cpu_step_ctrl u_dut (
    .clk(clk), .reset(reset),
    .step_pulse(step_pulse), .run_pulse(run_pulse),
    .stop_pulse(stop_pulse), .rst_req(rst_req),
    .run_count(run_count), .bp_en(bp_en),
    .bp_addr(bp_addr), .pc_in(pc),
    .cpu_en(cpu_en), .cpu_rst(cpu_rst),
    .halted(halted), .bp_hit(bp_hit),
    .state_o(state_o), .cyc_cnt(cyc_cnt)
  );

  cpu_step_ctrl #(.CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset4),
    .step_pulse(1'b0), .run_pulse(run4),
    .stop_pulse(1'b0), .rst_req(1'b0),
    .run_count(4'd0), .bp_en(1'b0),
    .bp_addr(32'd0), .pc_in(32'd0),
    .cpu_en(en4), .cpu_rst(rst4),
    .halted(halted4), .bp_hit(hit4),
    .state_o(state4), .cyc_cnt(cyc4)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic pulse_step();
    @(negedge clk); step_pulse = 1'b1;
    @(negedge clk); step_pulse = 1'b0;
  endtask

  task automatic pulse_run(input logic [15:0] cnt);
    @(negedge clk); run_count = cnt; run_pulse = 1'b1;
    @(negedge clk); run_pulse = 1'b0;
  endtask

  task automatic measure(input int cyc, output int cnt);
    cnt = 0;
    repeat (cyc) begin
      #1;
      if (cpu_en) cnt++;
      @(negedge clk);
    end
  endtask

  task automatic hold_len(output int cnt);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (!cpu_rst) break;
      cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b0; reset4 = 1'b0; run4 = 1'b0;
    step_pulse = 1'b0; run_pulse = 1'b0;
    stop_pulse = 1'b0; rst_req = 1'b0;
    run_count = '0; bp_en = 1'b0; bp_addr = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_state", state_o, 0);
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_cpu_en", cpu_en, 1);
    chk("rst_halted", halted, 0);
    chk("rst_cyc", cyc_cnt, 0);

    // 1: reset hold length
    @(negedge clk); reset = 1'b1; reset4 = 1'b1;
    hold_len(n);
    chk("hold_len", n, 4);
    chk("post_hold_state", state_o, 1);
    chk("post_hold_en", cpu_en, 0);
    chk("post_hold_cyc", cyc_cnt, 0);

    // 2: three single steps
    for (int s = 0; s < 3; s++) begin
      pulse_step();
      measure(5, n);
      chk("step_en_cycles", n, 1);
      #1 chk("step_halted", halted, 1);
    end
    chk("step_cyc", cyc_cnt, 3);

    // 3: run N, then run N cut short by stop
    pulse_run(16'd10);
    measure(14, n);
    chk("runn_en_cycles", n, 10);
    #1 chk("runn_state", state_o, 1);
    chk("runn_cyc", cyc_cnt, 13);
    pulse_run(16'd10);
    measure(3, n);
    chk("stop_pre_cycles", n, 3);
    stop_pulse = 1'b1;
    #1 chk("stop_mealy_en", cpu_en, 0);
    @(negedge clk); stop_pulse = 1'b0;
    #1 chk("stop_state", state_o, 1);
    chk("stop_cyc", cyc_cnt, 16);

    // 5: rst_req in the middle of RUN_N
    pulse_run(16'd10);
    measure(3, n);
    rst_req = 1'b1;
    @(negedge clk); rst_req = 1'b0;
    #1 chk("rreq_state", state_o, 0);
    chk("rreq_cyc", cyc_cnt, 0);
    hold_len(n);
    chk("rreq_hold_len", n, 4);
    chk("rreq_after_state", state_o, 1);
    chk("rreq_after_cyc", cyc_cnt, 0);

    // 4: breakpoint at 0x18 during free run
    bp_en = 1'b1; bp_addr = 32'h18;
    pulse_run(16'd0);
`ifdef CPU_STEP_BP_EN
    n = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!cpu_en) break;
      n++;
      @(negedge clk);
    end
    chk("bp_run_cycles", n, 6);
    chk("bp_freeze_pc", pc, 32'h18);
    @(negedge clk);
    #1 chk("bp_hit", bp_hit, 1);
    chk("bp_state", state_o, 5);
    chk("bp_halted", halted, 1);
    pulse_step();
    @(negedge clk);
    #1 chk("bp_step_pc", pc, 32'h1c);
    chk("bp_step_state", state_o, 1);
    chk("bp_step_hit", bp_hit, 0);
    chk("bp_cyc", cyc_cnt, 7);
`else
    measure(10, n);
    chk("nobp_run_cycles", n, 10);
    chk("nobp_pc", pc, 32'h28);
    stop_pulse = 1'b1;
    #1 chk("nobp_stop_en", cpu_en, 0);
    @(negedge clk); stop_pulse = 1'b0;
    #1 chk("nobp_state", state_o, 1);
    chk("nobp_hit", bp_hit, 0);
    chk("nobp_cyc", cyc_cnt, 10);
`endif

    // 6: CNT_W=4 saturation and asynchronous reset
    @(negedge clk); run4 = 1'b1;
    @(negedge clk); run4 = 1'b0;
    repeat (20) @(negedge clk);
    #1 chk("sat_cyc4", cyc4, 15);
    chk("sat_en4", en4, 1);
    chk("sat_state4", state4, 4);
    #2 reset4 = 1'b0;
    #1;
    chk("arst_state4", state4, 0);
    chk("arst_cyc4", cyc4, 0);
    chk("arst_rst4", rst4, 1);
    chk("arst_en4", en4, 1);
    chk("arst_halted4", halted4, 0);
    chk("arst_hit4", hit4, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cpu_step_ctrl.md
Name: cpu_step_ctrl

Overview:
Run-control sequencer for the pipelined MIPS core on the Basys3 board. Turns single-cycle button/debug pulses into a per-cycle enable and a synchronous reset for the processor. Supports single-step, run-N-cycles, free-run, stop and PC breakpoint. Sits between the pulse controllers and the processor instance; the core runs on the board clock gated by cpu_en.

Parameters:
PC_W, 32, width of pc_in and bp_addr
CNT_W, 16, width of run_count and cyc_cnt
RESET_CYCLES, 4, cycles cpu_rst is held after any reset request (>=1)

Ports:
clk  input  1  board clock; all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
step_pulse  input  1  one-cycle pulse: advance processor one cycle
run_pulse  input  1  one-cycle pulse: start run (N cycles, or free if run_count==0)
stop_pulse  input  1  one-cycle pulse: halt a run
rst_req  input  1  one-cycle pulse: reset processor
run_count  input  CNT_W  cycle budget sampled on run_pulse
bp_en  input  1  breakpoint enable
bp_addr  input  PC_W  breakpoint PC
pc_in  input  PC_W  processor fetch PC
cpu_en  output  1  processor clock enable
cpu_rst  output  1  processor synchronous reset, active-high
halted  output  1  state is HALTED or BREAK
bp_hit  output  1  high while in BREAK
state_o  output  3  current state encoding
cyc_cnt  output  CNT_W  count of cycles with cpu_en=1, saturating

Behaviour:
- States/encoding: RST_HOLD=0, HALTED=1, STEP=2, RUN_N=3, RUN_FREE=4, BREAK=5.
- reset low: state=RST_HOLD, hold counter=RESET_CYCLES-1, rem=0, cyc_cnt=0, bp_mask=1. Outputs: cpu_rst=1, cpu_en=1, halted=0, bp_hit=0, state_o=0.
- RST_HOLD: cpu_rst=1, cpu_en=1 so the core's synchronous reset is captured. Stays exactly RESET_CYCLES cycles, then HALTED. cyc_cnt is not incremented here.
- Priority in every state: rst_req > stop_pulse > step_pulse > run_pulse. rst_req enters RST_HOLD next cycle, clears cyc_cnt and rem, and reloads the hold counter; this applies mid-run and inside RST_HOLD.
- HALTED (cpu_en=0):
  - step_pulse -> STEP.
  - run_pulse with run_count==0 -> RUN_FREE.
  - run_pulse with run_count>0 -> RUN_N with rem=run_count.
  - step_pulse and run_pulse together: step wins.
- STEP: cpu_en=1 for exactly one cycle, then HALTED. All pulses except rst_req are ignored.
- RUN_N: cpu_en=1 each cycle; rem decrements on each enabled cycle. With rem==1 and enabled, go to HALTED next cycle, so exactly run_count enabled cycles.
- RUN_FREE: cpu_en=1 until stop, breakpoint or rst_req.
- stop_pulse in RUN_N/RUN_FREE: cpu_en forced 0 combinationally in the same cycle; next state HALTED; rem cleared.
- Breakpoint (feature-gated): in RUN_N/RUN_FREE, hit = bp_en && pc_in==bp_addr && !bp_mask.
  - On hit, cpu_en=0 in the same cycle (Mealy), so the processor freezes with PC==bp_addr.
  - Next state BREAK; rem cleared.
- bp_mask: set in HALTED/BREAK; cleared after the first enabled cycle of STEP/RUN_*. Resuming from a breakpoint therefore executes past it.
- BREAK: cpu_en=0, bp_hit=1, halted=1. Leaves on the same pulses as HALTED.
- step/run pulses while running are ignored.
- cyc_cnt increments on cpu_en && !cpu_rst and saturates at 2^CNT_W-1.

Optional Feature:
CPU_STEP_BP_EN
- Defined: breakpoint compare, bp_mask and BREAK state are present as described above.
- Undefined: bp_en/bp_addr are ignored, BREAK is unreachable and bp_hit is tied 0. The compare logic must synthesise away.

Decomposition:
- Package cpu_step_ctrl_pkg: state enum typedef (3-bit) with the fixed encodings, plus a localparam for the state width.
- One sub-module, sat_counter (parameterised width, enable, sync clear, async active-low reset), used for cyc_cnt. The rem and hold counters stay inline.

Test Plan:
1. Release reset with RESET_CYCLES=4 -> cpu_rst=1 for 4 cycles, then state_o=1, cpu_en=0, cyc_cnt=0.
2. Three step_pulses spaced 5 cycles apart -> exactly 3 single-cycle cpu_en highs; cyc_cnt=3; halted=1 between steps.
3. run_pulse with run_count=10 -> cpu_en high for exactly 10 consecutive cycles, then HALTED; cyc_cnt +10. Repeat with stop_pulse on the 4th enabled cycle -> 3 enabled cycles only.
4. Free-run with bp_en=1, bp_addr=0x0000_0018 and a core PC stepping by 4 from 0 -> cpu_en=0 in the cycle pc_in=0x18, then bp_hit=1. A following step_pulse advances PC to 0x1C without re-triggering. With the macro undefined, the run continues past 0x18.
5. rst_req mid RUN_N with rem=7 -> RST_HOLD next cycle, cpu_rst=1 for 4 cycles, cyc_cnt=0, then HALTED with rem=0.
6. Set CNT_W=4 and free-run 20 cycles -> cyc_cnt saturates at 15. Assert reset mid-run -> all outputs take their reset values asynchronously.
